// File: rtl/and_gate.sv
// and_gate: bitwise AND with a combinational result, a registered copy,
// an all-ones flag, a saturating all-ones counter and input-pair coverage.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   a, b       in   WIDTH-bit operands
//   in_valid   in   qualifies a/b for the registered path
//   c          out  a & b, combinational
//   c_q        out  a & b captured on the last valid edge
//   out_valid  out  c_q/all_ones were updated on the last edge
//   all_ones   out  registered &(a & b)
//   ones_count out  saturating count of valid all-ones results
//   combo_seen out  sticky {a[0],b[0]} pairs seen on valid cycles
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic [CNT_W-1:0] ones_count,
  output logic [3:0]       combo_seen
);

  logic [WIDTH-1:0] w_and;
  logic             w_all;
  logic [1:0]       w_idx;
  logic             w_sat;

  logic [WIDTH-1:0] r_cq;
  logic             r_vld;
  logic             r_all;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_seen;

  assign w_and = a & b;
  assign w_all = &w_and;
  // Index 1 = b only, 2 = a only.
  assign w_idx = {a[0], b[0]};
  // Counter sticks at its maximum instead of wrapping.
  assign w_sat = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cq   <= '0;
      r_vld  <= 1'b0;
      r_all  <= 1'b0;
      r_cnt  <= '0;
      r_seen <= '0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_cq          <= w_and;
        r_all         <= w_all;
        r_seen[w_idx] <= 1'b1;
        if (w_all && !w_sat) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign c          = w_and;
  assign c_q        = r_cq;
  assign out_valid  = r_vld;
  assign all_ones   = r_all;
  assign ones_count = r_cnt;
  assign combo_seen = r_seen;

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: vector tables, directed corner sequences and a
// randomized run against a reference model for and_gate.
module tb_and_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Main instance, WIDTH=1 CNT_W=16
  logic        rst, a, b, iv;
  logic        c, cq, ov, ao;
  logic [15:0] cnt;
  logic [3:0]  seen;

  and_gate #(.WIDTH(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(iv),
    .c(c), .c_q(cq), .out_valid(ov), .all_ones(ao),
    .ones_count(cnt), .combo_seen(seen)
  );

  // Saturation instance, CNT_W=2
  logic       s_rst, s_a, s_b, s_iv;
  logic       s_c, s_cq, s_ov, s_ao;
  logic [1:0] s_cnt;
  logic [3:0] s_seen;

  and_gate #(.WIDTH(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(s_rst), .a(s_a), .b(s_b), .in_valid(s_iv),
    .c(s_c), .c_q(s_cq), .out_valid(s_ov), .all_ones(s_ao),
    .ones_count(s_cnt), .combo_seen(s_seen)
  );

  // Wide instance for random run, WIDTH=4 CNT_W=3
  logic       w_rst, w_iv;
  logic [3:0] w_a, w_b, w_c, w_cq;
  logic       w_ov, w_ao;
  logic [2:0] w_cnt;
  logic [3:0] w_seen;

  and_gate #(.WIDTH(4), .CNT_W(3)) dut_w (
    .clk(clk), .rst(w_rst), .a(w_a), .b(w_b), .in_valid(w_iv),
    .c(w_c), .c_q(w_cq), .out_valid(w_ov), .all_ones(w_ao),
    .ones_count(w_cnt), .combo_seen(w_seen)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic all;
  } vec_t;

  vec_t tv[4];

  // Reference model state for the wide instance
  int m_cq, m_ov, m_ao, m_cnt, m_seen;

  initial begin
    tv[0] = '{a: 1'b0, b: 1'b0, c: 1'b0, all: 1'b0};
    tv[1] = '{a: 1'b1, b: 1'b0, c: 1'b0, all: 1'b0};
    tv[2] = '{a: 1'b0, b: 1'b1, c: 1'b0, all: 1'b0};
    tv[3] = '{a: 1'b1, b: 1'b1, c: 1'b1, all: 1'b1};

    rst = 1'b1; a = 1'b0; b = 1'b0; iv = 1'b0;
    s_rst = 1'b1; s_a = 1'b0; s_b = 1'b0; s_iv = 1'b0;
    w_rst = 1'b1; w_a = '0; w_b = '0; w_iv = 1'b0;

    // Combinational truth table
    for (int i = 0; i < 4; i++) begin
      a = tv[i].a;
      b = tv[i].b;
      #10;
      chk($sformatf("comb_c[%0d]", i), c, tv[i].c);
    end

    // Two reset edges, then reset state
    step();
    step();
    chk("rst_cq", cq, 0);
    chk("rst_ov", ov, 0);
    chk("rst_ao", ao, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_seen", seen, 0);
    chk("rst_s_cnt", s_cnt, 0);
    chk("rst_w_cnt", w_cnt, 0);
    chk("rst_w_ov", w_ov, 0);

    // Registered stream
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = tv[i].a;
      b = tv[i].b;
      iv = 1'b1;
      step();
      chk($sformatf("reg_cq[%0d]", i), cq, tv[i].c);
      chk($sformatf("reg_ao[%0d]", i), ao, tv[i].all);
      chk($sformatf("reg_ov[%0d]", i), ov, 1);
    end
    chk("cov_seen", seen, 4'b1111);
    chk("cov_cnt", cnt, 1);

    // Three more all-ones cycles
    for (int i = 0; i < 3; i++) begin
      a = 1'b1; b = 1'b1; iv = 1'b1;
      step();
      chk($sformatf("cnt_inc[%0d]", i), cnt, 2 + i);
    end

    // Hold with in_valid low while toggling operands
    iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = tv[i].a;
      b = tv[i].b;
      #1;
      chk($sformatf("hold_c[%0d]", i), c, tv[i].c);
      step();
      chk($sformatf("hold_ov[%0d]", i), ov, 0);
      chk($sformatf("hold_cq[%0d]", i), cq, 1);
      chk($sformatf("hold_ao[%0d]", i), ao, 1);
      chk($sformatf("hold_cnt[%0d]", i), cnt, 4);
      chk($sformatf("hold_seen[%0d]", i), seen, 4'b1111);
    end

    // Reset mid-operation with valid all-ones input
    rst = 1'b1; iv = 1'b1; a = 1'b1; b = 1'b1;
    step();
    chk("mid_cq", cq, 0);
    chk("mid_ov", ov, 0);
    chk("mid_ao", ao, 0);
    chk("mid_cnt", cnt, 0);
    chk("mid_seen", seen, 0);
    chk("mid_c", c, 1);

    // First edge after reset release captures data
    rst = 1'b0;
    step();
    chk("rel_cq", cq, 1);
    chk("rel_ov", ov, 1);
    chk("rel_cnt", cnt, 1);
    chk("rel_seen", seen, 4'b1000);
    iv = 1'b0;

    // Saturation at CNT_W=2
    s_rst = 1'b0; s_a = 1'b1; s_b = 1'b1; s_iv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat_cnt[%0d]", i), s_cnt, (i < 3) ? i + 1 : 3);
    end
    s_iv = 1'b0;

    // Randomized run on the wide instance
    m_cq = 0; m_ov = 0; m_ao = 0; m_cnt = 0; m_seen = 0;
    for (int t = 0; t < 400; t++) begin
      w_rst = ($urandom_range(0, 19) == 0);
      w_iv  = $urandom_range(0, 1);
      w_a   = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom);
      w_b   = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom);
      #1;
      chk("rnd_c", w_c, int'(w_a) & int'(w_b));
      if (w_rst) begin
        m_cq = 0; m_ov = 0; m_ao = 0; m_cnt = 0; m_seen = 0;
      end else begin
        m_ov = w_iv;
        if (w_iv) begin
          m_cq = int'(w_a) & int'(w_b);
          m_ao = (m_cq == 15) ? 1 : 0;
          m_seen = m_seen | (1 << (2 * int'(w_a[0]) + int'(w_b[0])));
          if (m_ao == 1 && m_cnt < 7) m_cnt = m_cnt + 1;
        end
      end
      step();
      chk("rnd_cq", w_cq, m_cq);
      chk("rnd_ov", w_ov, m_ov);
      chk("rnd_ao", w_ao, m_ao);
      chk("rnd_cnt", w_cnt, m_cnt);
      chk("rnd_seen", w_seen, m_seen);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
